// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution sequencer.
//   - vsew encodings (element width codes)
//   - sequencer FSM state enum
//   - default vector register width
//   - vec_vlmax(): number of elements of a given width in one register
package vec_pkg;

  localparam int VLEN_DEF = 128;

  typedef enum logic [2:0] {
    VSEW_8  = 3'd0,
    VSEW_16 = 3'd1,
    VSEW_32 = 3'd2,
    VSEW_64 = 3'd3
  } vsew_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_WB    = 3'd5
  } state_e;

  // VLEN / SEW, with SEW = 8 << vsew. Only meaningful for legal vsew codes.
  function automatic int unsigned vec_vlmax(input logic [2:0] vsew,
                                            input int unsigned vlen = VLEN_DEF);
    return vlen >> (3 + int'(vsew));
  endfunction

endpackage

// File: rtl/vec_tail_merge.sv
// Tail-undisturbed merge of an ALU result into the old destination value.
// Element i (SEW = 8 << vsew bits wide) takes res when i < vl_eff, else old.
// Ports:
//   res     in  VLEN  ALU result
//   old     in  VLEN  previous destination register contents
//   vsew    in  3     element width code
//   vl_eff  in  VL_W  active element count, already clamped to VLMAX
//   merged  out VLEN  value to write back
module vec_tail_merge #(
  parameter int VLEN = 128,
  parameter int VL_W = 10
) (
  input  logic [VLEN-1:0] res,
  input  logic [VLEN-1:0] old,
  input  logic [2:0]      vsew,
  input  logic [VL_W-1:0] vl_eff,
  output logic [VLEN-1:0] merged
);

  // Each bit's element index is its position divided by SEW, i.e. shifted
  // right by log2(SEW) = 3 + vsew.
  always_comb begin
    merged = old;
    for (int b = 0; b < VLEN; b++) begin
      if ((b >> (3 + int'(vsew))) < int'(vl_eff)) begin
        merged[b] = res[b];
      end
    end
  end

endmodule

// File: rtl/vec_exec_seq.sv
// Single-issue sequencer wrapped around vec_alu.
// Accepts one vector instruction, reads vs1/vs2/old vd from the register
// file, runs the ALU through its run/done handshake, merges the result with
// the old vd under vl (tail-undisturbed) and writes it back.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   issue_*                          instruction offer / accept handshake
//   vrf_raddr1..3 / vrf_rdata1..3    register file reads (1-cycle latency)
//   vrf_we / vrf_waddr / vrf_wdata   register file write-back
//   alu_run/opcode/vsew/vs1/vs2      ALU drive
//   alu_vd / alu_done                ALU result and completion
//   cmpl                             one-cycle retire pulse
//   err                              one-cycle reject pulse (illegal vsew)
module vec_exec_seq
  import vec_pkg::*;
#(
  parameter int VLEN    = VLEN_DEF,
  parameter int VREG_AW = 5,
  parameter int VL_W    = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [5:0]         issue_opcode,
  input  logic [VREG_AW-1:0] issue_vs1,
  input  logic [VREG_AW-1:0] issue_vs2,
  input  logic [VREG_AW-1:0] issue_vd,
  input  logic [2:0]         issue_vsew,
  input  logic [VL_W-1:0]    issue_vl,
  output logic [VREG_AW-1:0] vrf_raddr1,
  output logic [VREG_AW-1:0] vrf_raddr2,
  output logic [VREG_AW-1:0] vrf_raddr3,
  input  logic [VLEN-1:0]    vrf_rdata1,
  input  logic [VLEN-1:0]    vrf_rdata2,
  input  logic [VLEN-1:0]    vrf_rdata3,
  output logic               vrf_we,
  output logic [VREG_AW-1:0] vrf_waddr,
  output logic [VLEN-1:0]    vrf_wdata,
  output logic               alu_run,
  output logic [5:0]         alu_opcode,
  output logic [2:0]         alu_vsew,
  output logic [VLEN-1:0]    alu_vs1,
  output logic [VLEN-1:0]    alu_vs2,
  input  logic [VLEN-1:0]    alu_vd,
  input  logic               alu_done,
  output logic               cmpl,
  output logic               err
);

  state_e state_q, state_d;

  logic [5:0]         opcode_q;
  logic [VREG_AW-1:0] vs1_q, vs2_q, vd_q;
  logic [2:0]         vsew_q;
  logic [VL_W-1:0]    vl_q;
  logic [VL_W-1:0]    vl_eff_q;
  logic [VLEN-1:0]    op1_q, op2_q, old_q, res_q;
  logic               err_q;

  logic               issue_acc;
  logic               vsew_bad;
  int unsigned        vlmax;
  logic [VL_W-1:0]    vl_clamp;
  logic [VLEN-1:0]    merged;

  assign issue_acc = issue_valid && (state_q == ST_IDLE);
  assign vsew_bad  = (issue_vsew > VSEW_64);

  always_comb begin
    vlmax    = vec_vlmax(vsew_q, VLEN);
    vl_clamp = (32'(vl_q) < vlmax) ? vl_q : VL_W'(vlmax);
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (issue_acc && !vsew_bad) state_d = ST_READ;
      ST_READ:  state_d = ST_LATCH;
      ST_LATCH: state_d = (vl_q == '0) ? ST_WB : ST_RUN;
      ST_RUN:   if (alu_done) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    issue_ready = (state_q == ST_IDLE);
    alu_run     = (state_q == ST_RUN);
    cmpl        = (state_q == ST_WB);
    vrf_raddr1  = '0;
    vrf_raddr2  = '0;
    vrf_raddr3  = '0;
    vrf_we      = 1'b0;
    vrf_waddr   = '0;
    vrf_wdata   = '0;
    if (state_q == ST_READ) begin
      vrf_raddr1 = vs1_q;
      vrf_raddr2 = vs2_q;
      vrf_raddr3 = vd_q;
    end
    if (state_q == ST_WB) begin
      // vl_eff is zero exactly when vl was zero: retire without writing.
      vrf_we    = (vl_eff_q != '0);
      vrf_waddr = vd_q;
      vrf_wdata = merged;
    end
  end

  assign alu_opcode = opcode_q;
  assign alu_vsew   = vsew_q;
  assign alu_vs1    = op1_q;
  assign alu_vs2    = op2_q;
  assign err        = err_q;

  // ---- issue latch ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      opcode_q <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      vsew_q   <= '0;
      vl_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= issue_acc && vsew_bad;
      if (issue_acc) begin
        opcode_q <= issue_opcode;
        vs1_q    <= issue_vs1;
        vs2_q    <= issue_vs2;
        vd_q     <= issue_vd;
        vsew_q   <= issue_vsew;
        vl_q     <= issue_vl;
      end
    end
  end

  // ---- operand capture / result capture ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op1_q    <= '0;
      op2_q    <= '0;
      old_q    <= '0;
      res_q    <= '0;
      vl_eff_q <= '0;
    end else begin
      if (state_q == ST_LATCH) begin
        op1_q    <= vrf_rdata1;
        op2_q    <= vrf_rdata2;
        old_q    <= vrf_rdata3;
        vl_eff_q <= vl_clamp;
      end
      if ((state_q == ST_RUN) && alu_done) begin
        res_q <= alu_vd;
      end
    end
  end

  vec_tail_merge #(
    .VLEN (VLEN),
    .VL_W (VL_W)
  ) u_merge (
    .res    (res_q),
    .old    (old_q),
    .vsew   (vsew_q),
    .vl_eff (vl_eff_q),
    .merged (merged)
  );

endmodule
